// File: rtl/ysyx_22050550_seqdiv_pkg.sv
// Shared definitions for the sequential divider: state encoding, datapath
// width, iteration counts, and the early-out build option.
// Build option: define YSYX_22050550_DIV_EARLYOUT_EN to let divide-by-zero
// and signed-overflow requests skip the iteration phase.
package ysyx_22050550_seqdiv_pkg;

  localparam int XLEN = 64;

  // Number of restoring steps for full-width and W (32-bit) operations.
  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

`ifdef YSYX_22050550_DIV_EARLYOUT_EN
  localparam logic EARLYOUT_EN = 1'b1;
`else
  localparam logic EARLYOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Sign-extend a 32-bit value to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Turn magnitudes into the architectural results: apply signs, then
  // substitute the divide-by-zero / signed-overflow results, then narrow
  // to W width if needed. Returns {quotient, remainder}.
  function automatic logic [127:0] fix_result(
    input logic [63:0] q_mag,
    input logic [63:0] r_mag,
    input logic        neg_q,
    input logic        neg_r,
    input logic        w,
    input logic        dz,
    input logic        ovf,
    input logic [63:0] dividend
  );
    logic [63:0] q;
    logic [63:0] r;
    q = neg_q ? (64'd0 - q_mag) : q_mag;
    r = neg_r ? (64'd0 - r_mag) : r_mag;
    if (dz) begin
      q = {64{1'b1}};
      r = dividend;
    end else if (ovf) begin
      q = dividend;
      r = 64'd0;
    end
    if (w) begin
      q = sext32(q[31:0]);
      r = sext32(r[31:0]);
    end
    return {q, r};
  endfunction

endpackage

// File: rtl/ysyx_22050550_DivStep.sv
// One radix-2 restoring division step on a {remainder, dividend/quotient}
// partial-remainder register: shift left, trial subtract, set quotient bit.
module ysyx_22050550_DivStep
  import ysyx_22050550_seqdiv_pkg::*;
(
  input  logic [2*XLEN-1:0] pr_in,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] pr_out
);

  logic [2*XLEN:0] shifted;
  logic [XLEN:0]   trial;

  // Shift, trial subtract; keep the difference only if it did not borrow.
  // The shifted upper half is always < 2*divisor, so bit XLEN of the
  // difference is a reliable borrow flag.
  always_comb begin
    shifted = {pr_in, 1'b0};
    trial   = shifted[2*XLEN:XLEN] - {1'b0, divisor};
    if (trial[XLEN]) begin
      pr_out = shifted[2*XLEN-1:0];
    end else begin
      pr_out = {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/ysyx_22050550_seqdiv.sv
// Sequential restoring divider (64-bit and W/32-bit, signed/unsigned).
// One quotient bit per cycle on operand magnitudes; signs and the
// divide-by-zero / overflow results are applied when the result is written.
// Build option: YSYX_22050550_DIV_EARLYOUT_EN (see package) finishes
// divide-by-zero and signed-overflow requests one cycle after accept.
module ysyx_22050550_seqdiv
  import ysyx_22050550_seqdiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Exu_DivValid,
  input  logic            io_Exu_Flush,
  input  logic            io_Exu_Divw,
  input  logic [1:0]      io_Exu_DivSigned,
  input  logic [XLEN-1:0] io_Exu_Divdend,
  input  logic [XLEN-1:0] io_Exu_Divisor,
  output logic            io_Exu_DivReady,
  output logic            io_Exu_OutValid,
  output logic [XLEN-1:0] io_Exu_Quotient,
  output logic [XLEN-1:0] io_Exu_Remainder
);

  div_state_t   state;
  logic [6:0]   cnt;
  logic [127:0] pr;
  logic [63:0]  dvs_mag;
  logic [63:0]  dividend_raw;
  logic [63:0]  quotient;
  logic [63:0]  remainder;
  logic         w_mode;
  logic         neg_q;
  logic         neg_r;
  logic         div_zero;
  logic         ovf;

  logic [63:0]  a_ext;
  logic [63:0]  b_ext;
  logic [63:0]  a_mag;
  logic [63:0]  b_mag;
  logic         a_neg;
  logic         b_neg;
  logic         in_zero;
  logic         in_ovf;
  logic [127:0] pr_load;
  logic [127:0] pr_next;
  logic [127:0] fin_res;
  logic [127:0] early_res;
  logic         accept;

  // Condition incoming operands: W-mode extension, signs, magnitudes and
  // special-case detection, all from the raw request.
  always_comb begin
    if (io_Exu_Divw) begin
      a_ext = io_Exu_DivSigned[1] ? sext32(io_Exu_Divdend[31:0]) : {32'd0, io_Exu_Divdend[31:0]};
      b_ext = io_Exu_DivSigned[0] ? sext32(io_Exu_Divisor[31:0]) : {32'd0, io_Exu_Divisor[31:0]};
    end else begin
      a_ext = io_Exu_Divdend;
      b_ext = io_Exu_Divisor;
    end
    a_neg   = io_Exu_DivSigned[1] & a_ext[63];
    b_neg   = io_Exu_DivSigned[0] & b_ext[63];
    a_mag   = a_neg ? (64'd0 - a_ext) : a_ext;
    b_mag   = b_neg ? (64'd0 - b_ext) : b_ext;
    // W dividend sits at [63:32] so that after 32 steps the quotient lands
    // in [31:0] and the remainder in the upper half.
    pr_load = io_Exu_Divw ? {64'd0, a_mag[31:0], 32'd0} : {64'd0, a_mag};
    in_zero = (b_ext == 64'd0);
    if (io_Exu_DivSigned != 2'b11) begin
      in_ovf = 1'b0;
    end else if (io_Exu_Divw) begin
      in_ovf = (io_Exu_Divdend[31:0] == 32'h8000_0000) && (io_Exu_Divisor[31:0] == 32'hFFFF_FFFF);
    end else begin
      in_ovf = (io_Exu_Divdend == 64'h8000_0000_0000_0000) && (io_Exu_Divisor == 64'hFFFF_FFFF_FFFF_FFFF);
    end
  end

  assign accept = (state == IDLE) & io_Exu_DivValid & ~io_Exu_Flush;

  ysyx_22050550_DivStep u_step (
    .pr_in   (pr),
    .divisor (dvs_mag),
    .pr_out  (pr_next)
  );

  // Final results from the last step, and direct results for the early-out path.
  always_comb begin
    fin_res   = fix_result(w_mode ? {32'd0, pr_next[31:0]} : pr_next[63:0], pr_next[127:64],
                           neg_q, neg_r, w_mode, div_zero, ovf, dividend_raw);
    early_res = fix_result(64'd0, 64'd0, 1'b0, 1'b0, io_Exu_Divw, in_zero, in_ovf, io_Exu_Divdend);
  end

  // Control FSM, iteration counter, partial remainder and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 7'd0;
      pr           <= 128'd0;
      dvs_mag      <= 64'd0;
      dividend_raw <= 64'd0;
      w_mode       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      ovf          <= 1'b0;
      quotient     <= 64'd0;
      remainder    <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pr           <= pr_load;
            dvs_mag      <= b_mag;
            dividend_raw <= io_Exu_Divdend;
            w_mode       <= io_Exu_Divw;
            neg_q        <= a_neg ^ b_neg;
            neg_r        <= a_neg;
            div_zero     <= in_zero;
            ovf          <= in_ovf;
            if (EARLYOUT_EN && (in_zero || in_ovf)) begin
              state                 <= DONE;
              cnt                   <= 7'd0;
              {quotient, remainder} <= early_res;
            end else begin
              state <= CALC;
              cnt   <= io_Exu_Divw ? ITER_W : ITER_D;
            end
          end
        end
        CALC: begin
          if (io_Exu_Flush) begin
            state <= IDLE;
          end else begin
            pr  <= pr_next;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
              state                 <= DONE;
              {quotient, remainder} <= fin_res;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io_Exu_DivReady  = (state == IDLE);
  assign io_Exu_OutValid  = (state == DONE) & ~io_Exu_Flush;
  assign io_Exu_Quotient  = quotient;
  assign io_Exu_Remainder = remainder;

endmodule

// File: tb/tb_ysyx_22050550_seqdiv.sv
// Self-checking bench for ysyx_22050550_seqdiv: directed vectors with
// literal expectations, a wide-integer reference model and a per-cycle
// compare process for OutValid, DivReady, Quotient and Remainder.
module tb_ysyx_22050550_seqdiv;

  logic        clock;
  logic        reset;
  logic        div_valid;
  logic        flush;
  logic        divw;
  logic [1:0]  div_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          en = 1'b0;
  bit          pending = 1'b0;
  int          due_c = 0;
  logic [63:0] exp_q = 64'd0;
  logic [63:0] exp_r = 64'd0;
  logic [63:0] hold_q = 64'd0;
  logic [63:0] hold_r = 64'd0;

`ifdef YSYX_22050550_DIV_EARLYOUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  ysyx_22050550_seqdiv dut (
    .clock            (clock),
    .reset            (reset),
    .io_Exu_DivValid  (div_valid),
    .io_Exu_Flush     (flush),
    .io_Exu_Divw      (divw),
    .io_Exu_DivSigned (div_signed),
    .io_Exu_Divdend   (dividend),
    .io_Exu_Divisor   (divisor),
    .io_Exu_DivReady  (div_ready),
    .io_Exu_OutValid  (out_valid),
    .io_Exu_Quotient  (quotient),
    .io_Exu_Remainder (remainder)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: exact integer division on wide signed values (truncating,
  // remainder follows dividend), with the divide-by-zero rule on top.
  function automatic void model(input logic w, input logic [1:0] s, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output bit special);
    logic [63:0] ae;
    logic [63:0] be;
    logic signed [129:0] av;
    logic signed [129:0] bv;
    logic signed [129:0] qv;
    logic signed [129:0] rv;
    logic signed [129:0] lim;
    ae = w ? (s[1] ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    be = w ? (s[0] ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    av = s[1] ? {{66{ae[63]}}, ae} : {66'd0, ae};
    bv = s[0] ? {{66{be[63]}}, be} : {66'd0, be};
    lim = 130'sd1;
    lim = lim <<< (w ? 31 : 63);
    if (bv == 130'sd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF;
      r = ae;
      special = 1'b1;
    end else begin
      qv = av / bv;
      rv = av % bv;
      q = qv[63:0];
      r = rv[63:0];
      special = (s == 2'b11) && (qv >= lim);
    end
    if (w) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
  endfunction

  // Per-cycle comparison of DUT outputs against the expected schedule.
  always @(negedge clock) begin
    if (en) begin
      logic ev;
      ev = pending && (cyc == due_c);
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("div_ready", {63'd0, div_ready}, {63'd0, !pending});
      if (ev) begin
        hold_q = exp_q;
        hold_r = exp_r;
        pending = 1'b0;
      end
      chk("quotient", quotient, hold_q);
      chk("remainder", remainder, hold_r);
    end
  end

  task automatic do_div(input logic w, input logic [1:0] s, input logic [63:0] a,
                        input logic [63:0] b, input int hold,
                        input logic [63:0] lit_q, input logic [63:0] lit_r);
    logic [63:0] mq;
    logic [63:0] mr;
    logic [63:0] gq;
    logic [63:0] gr;
    bit sp;
    bit seen;
    int lat;
    int lat_exp;
    model(w, s, a, b, mq, mr, sp);
    chk("model_q", mq, lit_q);
    chk("model_r", mr, lit_r);
    lat_exp = (EARLY && sp) ? 1 : (w ? 33 : 65);
    @(posedge clock); #1;
    div_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
    @(posedge clock); #1;
    due_c = cyc + lat_exp - 1;
    exp_q = mq;
    exp_r = mr;
    pending = 1'b1;
    if (hold == 0) div_valid = 1'b0;
    seen = 1'b0; lat = 0; gq = 64'd0; gr = 64'd0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1; lat = i; gq = quotient; gr = remainder;
      end
      if (i >= hold) div_valid = 1'b0;
    end
    if (!seen) pending = 1'b0;
    chk("latency", 64'(lat), 64'(lat_exp));
    chk("result_q", gq, lit_q);
    chk("result_r", gr, lit_r);
  endtask

  initial begin
    reset = 1'b1; div_valid = 1'b0; flush = 1'b0; divw = 1'b0;
    div_signed = 2'b00; dividend = 64'd0; divisor = 64'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    en = 1'b1;

    do_div(1'b0, 2'b00, 64'd100, 64'd7, 0, 64'd14, 64'd2);
    do_div(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    do_div(1'b1, 2'b11, 64'h0000_0001_8000_0000, 64'd1, 0, 64'hFFFF_FFFF_8000_0000, 64'd0);
    do_div(1'b0, 2'b00, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    do_div(1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0,
           64'h8000_0000_0000_0000, 64'd0);
    do_div(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 0, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF);
    do_div(1'b1, 2'b00, 64'hDEAD_BEEF_FFFF_FFFE, 64'd3, 0, 64'h0000_0000_5555_5554, 64'd2);
    do_div(1'b1, 2'b11, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8765_4321);
    do_div(1'b0, 2'b11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2);

    // Flush during the tenth CALC cycle: no result, ready right after.
    @(posedge clock); #1;
    div_valid = 1'b1; divw = 1'b0; div_signed = 2'b00; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clock); #1;
    due_c = cyc + 64; exp_q = 64'd333; exp_r = 64'd1; pending = 1'b1; div_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    pending = 1'b0;
    @(negedge clock);
    chk("flush_ready", {63'd0, div_ready}, 64'd1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    repeat (70) @(negedge clock);

    // New request after flush, with DivValid held high into CALC.
    do_div(1'b0, 2'b00, 64'd9, 64'd3, 20, 64'd3, 64'd0);

    // Reset in the middle of CALC: back to IDLE with cleared results.
    @(posedge clock); #1;
    div_valid = 1'b1; divw = 1'b0; div_signed = 2'b00; dividend = 64'd77; divisor = 64'd5;
    @(posedge clock); #1;
    due_c = cyc + 64; exp_q = 64'd15; exp_r = 64'd2; pending = 1'b1; div_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    pending = 1'b0;
    hold_q = 64'd0;
    hold_r = 64'd0;
    @(negedge clock);
    chk("rst_ready", {63'd0, div_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    repeat (70) @(negedge clock);

    // DivValid together with Flush in IDLE must not be accepted.
    @(posedge clock); #1;
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd50; divisor = 64'd5;
    @(posedge clock); #1;
    div_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("vf_ready", {63'd0, div_ready}, 64'd1);
    repeat (70) @(negedge clock);

    do_div(1'b1, 2'b00, 64'd100, 64'd7, 0, 64'd14, 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_seqdiv.md
YSYX_22050550_SEQDIV -- requirements
Module: ysyx_22050550_seqdiv

Interface
REQ-001 SHALL have ports (name, direction, width, meaning), with clock and reset first:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-002 SHALL have the request ports:
- io_Exu_DivValid  in  1  request valid.
- io_Exu_Flush  in  1  abort the current operation.
- io_Exu_Divw  in  1  32-bit (W) operation.
- io_Exu_DivSigned  in  2  [1] dividend signed, [0] divisor signed.
- io_Exu_Divdend  in  64  dividend.
- io_Exu_Divisor  in  64  divisor.
REQ-003 SHALL have the response ports:
- io_Exu_DivReady  out  1  can accept a request.
- io_Exu_OutValid  out  1  result valid, one-cycle pulse.
- io_Exu_Quotient  out  64  quotient.
- io_Exu_Remainder  out  64  remainder.
REQ-004 Clocking/reset: reset reset, synchronous, active-high; clock clock.

Function
REQ-005 States SHALL be IDLE, CALC and DONE; encoding is 2 bits.
REQ-006 DivReady SHALL be 1 only in IDLE.
REQ-007 Accept SHALL occur on the edge where DivValid & DivReady & !Flush.
- On accept: latch operands, mode and signs; load the iteration counter N (N=64 if !Divw, N=32 if Divw); go to CALC.
REQ-008 CALC SHALL perform one radix-2 restoring step per cycle on operand magnitudes, with a 128-bit partial remainder (64-bit for W).
- After N steps the state goes to DONE.
- Accept at edge k gives OutValid in cycle k+N+1.
REQ-009 DONE SHALL last exactly one cycle, with OutValid=1, then return to IDLE; no output back-pressure exists.
REQ-010 Sign fix-up:
- Quotient is negated iff the effective operand signs differ.
- Remainder takes the sign of the dividend.
- Both are applied at the CALC->DONE transition.
REQ-011 Divide by zero SHALL give Quotient = all ones (of width) and Remainder = dividend.
REQ-012 Signed overflow (dividend = most-negative, divisor = -1, signed) SHALL give Quotient = dividend and Remainder = 0.
REQ-013 W mode:
- Only operand bits [31:0] are used.
- Sign bits are taken at bit 31.
- Both results are sign-extended from bit 31 to 64 bits.
REQ-014 Quotient/Remainder SHALL remain stable from DONE until the next accept.
REQ-015 Flush in CALC or DONE SHALL force IDLE on the next edge.
- OutValid = (state==DONE) & !Flush.
- Result registers keep their old values.
REQ-016 Flush asserted together with DivValid in IDLE SHALL prevent the accept.
REQ-017 A DivValid held high during CALC SHALL be ignored; the request is not re-accepted until IDLE.

Reset
REQ-018 On reset the state SHALL be IDLE, with the counter, Quotient, Remainder and internal registers = 0.
REQ-019 Outputs during reset: DivReady=1 and OutValid=0 in the cycle after reset.
REQ-020 Reset mid-CALC SHALL abort the operation with no OutValid pulse.

Configuration
REQ-021 Macro YSYX_22050550_DIV_EARLYOUT_EN:
- Defined: divide-by-zero and signed-overflow requests go from the accept edge straight to DONE, with OutValid at k+1.
- Undefined: these requests take the full N cycles, and REQ-011/012 results are substituted at the CALC->DONE transition.
- Results SHALL be identical in both builds.

Structure
REQ-022 The shared package/define file SHALL hold: the state encodings, XLEN=64, the iteration counts 64/32, and the macro name.
REQ-023 The single restoring step (shift, trial subtract, quotient bit) SHALL be the sub-module ysyx_22050550_DivStep, instantiated once.

Verification
REQ-024 100/7, unsigned, 64-bit -> Q=14, R=2; OutValid exactly 65 cycles after the accept edge; DivReady=0 throughout.
REQ-025 -7/2, DivSigned=11 -> Q=-3 (0xFFFF_FFFF_FFFF_FFFD), R=-1.
REQ-026 W mode, 0x0000_0001_8000_0000 / 1, signed -> Q=0xFFFF_FFFF_8000_0000, R=0; OutValid 33 cycles after accept.
REQ-027 Special cases (latency 1 cycle with the macro, 65 cycles without):
- 5/0 -> Q=0xFFFF_FFFF_FFFF_FFFF, R=5.
- 0x8000_0000_0000_0000 / -1 signed -> Q=0x8000_0000_0000_0000, R=0.
REQ-028 Flush at cycle 10 of CALC -> no OutValid; DivReady=1 next cycle; a new request 9/3 then gives Q=3, R=0.
REQ-029 Reset asserted mid-CALC -> IDLE with all outputs 0 and DivReady=1; DivValid+Flush together in IDLE -> no accept.
